// File: rtl/pipe_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl_if
// Purpose  : Pipeline-side hazard inputs and controller-side enable/flush outputs.
// Revision : 1.0 - initial release
// ============================================================================
interface pipe_hazard_ctrl_if;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_uses_rt;
    logic        ex_mem_read;
    logic [4:0]  ex_rt;
    logic        ex_branch_taken;
    logic        ex_muldiv_start;
    logic        ex_muldiv_div;
    logic        pc_write;
    logic        if_id_write;
    logic        if_id_flush;
    logic        id_ex_write;
    logic        id_ex_flush;
    logic        ex_mem_bubble;
    logic        muldiv_busy;
    logic        muldiv_done;
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;

    modport master (
        output id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt,
               ex_branch_taken, ex_muldiv_start, ex_muldiv_div,
        input  pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush,
               ex_mem_bubble, muldiv_busy, muldiv_done, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt,
               ex_branch_taken, ex_muldiv_start, ex_muldiv_div,
        output pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush,
               ex_mem_bubble, muldiv_busy, muldiv_done, stall_cnt, flush_cnt
    );
endinterface
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl
// Purpose  : Load-use stall, branch squash and MULT/DIV EX-occupancy control.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl #(
    parameter int MULT_CYCLES = 4,
    parameter int DIV_CYCLES  = 32
) (
    input  logic              clk,
    input  logic              rst,
    pipe_hazard_ctrl_if.slave hz
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;

    // BUSY length excludes the start cycle and the done cycle.
    localparam logic [5:0] c_mult_load = 6'(MULT_CYCLES - 2);
    localparam logic [5:0] c_div_load  = 6'(DIV_CYCLES - 2);
    localparam logic [15:0] c_cnt_max  = 16'hFFFF;

    logic [0:0]  r_state;
    logic [5:0]  r_cnt;
    logic [15:0] r_stall_cnt;
    logic [15:0] r_flush_cnt;

    logic w_load_use;
    logic w_pc_write;
    logic w_if_id_write;
    logic w_if_id_flush;
    logic w_id_ex_write;
    logic w_id_ex_flush;
    logic w_ex_mem_bubble;
    logic w_busy;
    logic w_done;
    logic w_flush_evt;
    logic w_start_evt;

    always_comb begin
        w_load_use = hz.ex_mem_read && (hz.ex_rt != 5'd0) &&
                     ((hz.ex_rt == hz.id_rs) ||
                      (hz.id_uses_rt && (hz.ex_rt == hz.id_rt)));

        w_pc_write      = 1'b1;
        w_if_id_write   = 1'b1;
        w_if_id_flush   = 1'b0;
        w_id_ex_write   = 1'b1;
        w_id_ex_flush   = 1'b0;
        w_ex_mem_bubble = 1'b0;
        w_busy          = 1'b0;
        w_done          = 1'b0;
        w_flush_evt     = 1'b0;
        w_start_evt     = 1'b0;

        if (!rst) begin
            if (r_state == S_IDLE) begin
                if (hz.ex_branch_taken) begin
                    w_if_id_flush = 1'b1;
                    w_id_ex_flush = 1'b1;
                    w_flush_evt   = 1'b1;
                end else if (hz.ex_muldiv_start) begin
                    w_pc_write      = 1'b0;
                    w_if_id_write   = 1'b0;
                    w_id_ex_write   = 1'b0;
                    w_ex_mem_bubble = 1'b1;
                    w_start_evt     = 1'b1;
                end else if (w_load_use) begin
                    w_pc_write    = 1'b0;
                    w_if_id_write = 1'b0;
                    w_id_ex_flush = 1'b1;
                end
            end else begin
                w_busy = 1'b1;
                if (r_cnt != 6'd0) begin
                    w_pc_write      = 1'b0;
                    w_if_id_write   = 1'b0;
                    w_id_ex_write   = 1'b0;
                    w_ex_mem_bubble = 1'b1;
                end else begin
                    w_done = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= 6'd0;
            r_stall_cnt <= 16'd0;
            r_flush_cnt <= 16'd0;
        end else begin
            if (r_state == S_IDLE) begin
                if (w_start_evt) begin
                    r_state <= S_BUSY;
                    r_cnt   <= hz.ex_muldiv_div ? c_div_load : c_mult_load;
                end
            end else if (r_cnt == 6'd0) begin
                r_state <= S_IDLE;
            end else begin
                r_cnt <= r_cnt - 6'd1;
            end

            if (!w_pc_write && (r_stall_cnt != c_cnt_max))
                r_stall_cnt <= r_stall_cnt + 16'd1;
            if (w_flush_evt && (r_flush_cnt != c_cnt_max))
                r_flush_cnt <= r_flush_cnt + 16'd1;
        end
    end

    assign hz.pc_write      = w_pc_write;
    assign hz.if_id_write   = w_if_id_write;
    assign hz.if_id_flush   = w_if_id_flush;
    assign hz.id_ex_write   = w_id_ex_write;
    assign hz.id_ex_flush   = w_id_ex_flush;
    assign hz.ex_mem_bubble = w_ex_mem_bubble;
    assign hz.muldiv_busy   = w_busy;
    assign hz.muldiv_done   = w_done;
    assign hz.stall_cnt     = r_stall_cnt;
    assign hz.flush_cnt     = r_flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_hazard_ctrl
// Purpose  : Directed and random checks of pipe_hazard_ctrl against a cycle model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

    localparam int MC = 4;
    localparam int DC = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipe_hazard_ctrl_if bus ();

    pipe_hazard_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (bus.slave)
    );

    int errors = 0;
    int checks = 0;

    // Model: cycles of the current muldiv still to come after this one (0 = idle).
    int m_left  = 0;
    int m_stall = 0;
    int m_flush = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush, bubble, busy, done}
    function automatic logic [7:0] model_ctl();
        logic hazard;
        hazard = bus.ex_mem_read && (bus.ex_rt != 0) &&
                 (bus.ex_rt == bus.id_rs || (bus.id_uses_rt && bus.ex_rt == bus.id_rt));
        if (rst)                      return 8'b1101_0000;
        if (m_left > 1)               return 8'b0000_0110;
        if (m_left == 1)              return 8'b1101_0011;
        if (bus.ex_branch_taken)      return 8'b1111_1000;
        if (bus.ex_muldiv_start)      return 8'b0000_0100;
        if (hazard)                   return 8'b0001_1000;
        return 8'b1101_0000;
    endfunction

    always @(posedge clk) begin
        logic [7:0] e;
        e = model_ctl();
        if (rst) begin
            m_left = 0; m_stall = 0; m_flush = 0;
        end else begin
            if (m_left > 0) m_left = m_left - 1;
            else if (bus.ex_branch_taken) m_flush = (m_flush < 65535) ? m_flush + 1 : 65535;
            else if (bus.ex_muldiv_start) m_left = (bus.ex_muldiv_div ? DC : MC) - 1;
            if (!e[7]) m_stall = (m_stall < 65535) ? m_stall + 1 : 65535;
        end
    end

    always @(negedge clk) begin
        logic [7:0] e;
        e = model_ctl();
        check("pc_write",      32'(bus.pc_write),      32'(e[7]));
        check("if_id_write",   32'(bus.if_id_write),   32'(e[6]));
        check("if_id_flush",   32'(bus.if_id_flush),   32'(e[5]));
        check("id_ex_write",   32'(bus.id_ex_write),   32'(e[4]));
        check("id_ex_flush",   32'(bus.id_ex_flush),   32'(e[3]));
        check("ex_mem_bubble", 32'(bus.ex_mem_bubble), 32'(e[2]));
        check("muldiv_busy",   32'(bus.muldiv_busy),   32'(e[1]));
        check("muldiv_done",   32'(bus.muldiv_done),   32'(e[0]));
        check("stall_cnt",     32'(bus.stall_cnt),     32'(m_stall));
        check("flush_cnt",     32'(bus.flush_cnt),     32'(m_flush));
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        bus.id_rs = 0; bus.id_rt = 0; bus.id_uses_rt = 0;
        bus.ex_mem_read = 0; bus.ex_rt = 0; bus.ex_branch_taken = 0;
        bus.ex_muldiv_start = 0; bus.ex_muldiv_div = 0;
    endtask

    initial begin
        int stalls;
        logic [3:0] busy_pat;
        logic [3:0] done_pat;
        int hold;
        logic seen;

        idle_in();
        rst = 1;
        cyc(); cyc();
        @(negedge clk);
        check("reset stall_cnt", 32'(bus.stall_cnt), 32'd0);
        check("reset pc_write",  32'(bus.pc_write),  32'd1);
        cyc();
        rst = 0;

        // load-use on rs
        bus.ex_mem_read = 1; bus.ex_rt = 8; bus.id_rs = 8;
        @(negedge clk);
        check("lu pc_write",    32'(bus.pc_write),    32'd0);
        check("lu if_id_write", 32'(bus.if_id_write), 32'd0);
        check("lu id_ex_flush", 32'(bus.id_ex_flush), 32'd1);
        cyc(); idle_in();
        @(negedge clk);
        check("lu stall_cnt", 32'(bus.stall_cnt), 32'd1);
        check("lu released",  32'(bus.pc_write),  32'd1);
        cyc();
        bus.ex_mem_read = 1; bus.ex_rt = 0; bus.id_rs = 0;
        @(negedge clk);
        check("r0 no stall", 32'(bus.pc_write), 32'd1);
        cyc(); idle_in();

        // rt-only dependency
        bus.ex_mem_read = 1; bus.ex_rt = 9; bus.id_rt = 9; bus.id_rs = 3; bus.id_uses_rt = 1;
        @(negedge clk);
        check("rt stall", 32'(bus.pc_write), 32'd0);
        cyc();
        bus.id_uses_rt = 0;
        @(negedge clk);
        check("rt unused", 32'(bus.pc_write), 32'd1);
        cyc(); idle_in();

        // branch beats load-use
        bus.ex_branch_taken = 1; bus.ex_mem_read = 1; bus.ex_rt = 8; bus.id_rs = 8;
        @(negedge clk);
        check("br if_id_flush", 32'(bus.if_id_flush), 32'd1);
        check("br id_ex_flush", 32'(bus.id_ex_flush), 32'd1);
        check("br pc_write",    32'(bus.pc_write),    32'd1);
        cyc(); idle_in();
        @(negedge clk);
        check("br flush_cnt", 32'(bus.flush_cnt), 32'd1);
        check("br stall_cnt", 32'(bus.stall_cnt), 32'd2);
        cyc();

        // MULT, start held through the op
        stalls = 0; busy_pat = 0; done_pat = 0;
        bus.ex_muldiv_start = 1; bus.ex_muldiv_div = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (!bus.pc_write) stalls++;
            if (k < 4) begin
                busy_pat[k] = bus.muldiv_busy;
                done_pat[k] = bus.muldiv_done;
            end else begin
                check("mult after idle busy", 32'(bus.muldiv_busy), 32'd0);
            end
            cyc();
            if (k == 3) bus.ex_muldiv_start = 0;
        end
        check("mult stalls",   32'(stalls),   32'd3);
        check("mult busy pat", 32'(busy_pat), 32'b1110);
        check("mult done pat", 32'(done_pat), 32'b1000);

        // DIV
        hold = 0; seen = 0;
        bus.ex_muldiv_start = 1; bus.ex_muldiv_div = 1;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (!bus.pc_write) hold++;
            seen = bus.muldiv_done;
            cyc();
        end
        idle_in();
        check("div done seen", 32'(seen), 32'd1);
        check("div holds",     32'(hold), 32'd31);
        @(negedge clk);
        check("div stall_cnt", 32'(bus.stall_cnt), 32'd36);
        cyc();

        // reset during BUSY at cnt=10
        bus.ex_muldiv_start = 1; bus.ex_muldiv_div = 1;
        seen = 0;
        for (int k = 0; k < 21; k++) begin
            @(negedge clk);
            seen = seen | bus.muldiv_done;
            cyc();
        end
        rst = 1;
        @(negedge clk);
        check("rst forces idle", 32'(bus.muldiv_busy), 32'd0);
        cyc();
        rst = 0; idle_in();
        @(negedge clk);
        check("post rst busy",  32'(bus.muldiv_busy), 32'd0);
        check("post rst done",  32'(bus.muldiv_done | seen), 32'd0);
        check("post rst stall", 32'(bus.stall_cnt), 32'd0);
        check("post rst flush", 32'(bus.flush_cnt), 32'd0);
        cyc();

        // random traffic
        for (int k = 0; k < 3000; k++) begin
            bus.id_rs = 5'($urandom_range(0, 3));
            bus.id_rt = 5'($urandom_range(0, 3));
            bus.ex_rt = 5'($urandom_range(0, 3));
            bus.id_uses_rt = 1'($urandom_range(0, 1));
            bus.ex_mem_read = ($urandom_range(0, 2) == 0);
            bus.ex_branch_taken = ($urandom_range(0, 7) == 0);
            bus.ex_muldiv_start = ($urandom_range(0, 9) == 0);
            bus.ex_muldiv_div = ($urandom_range(0, 3) == 0);
            rst = ($urandom_range(0, 199) == 0);
            cyc();
        end
        rst = 1; idle_in();
        cyc();
        rst = 0;

        // stall counter saturation via a persistent load-use hazard
        bus.ex_mem_read = 1; bus.ex_rt = 5; bus.id_rs = 5;
        for (int k = 0; k < 65540; k++) cyc();
        @(negedge clk);
        check("stall sat", 32'(bus.stall_cnt), 32'hFFFF);
        cyc();
        @(negedge clk);
        check("stall sat hold", 32'(bus.stall_cnt), 32'hFFFF);
        idle_in();
        cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
